karaoke_pio_in_edge: RTL
========================

# karaoke_pio_in_edge

Avalon-MM slave input port with synchronizer, per-bit debounce, edge capture and maskable interrupt. It is the read-side counterpart of the QSYS output PIOs: the Nios HPS/master reads board-level inputs through it (KEY pushbuttons, play/record request lines) and takes an IRQ on a qualified edge. It sits in the QSYS system on the same Avalon bus and clock as the output PIOs.

## Interface
- `WIDTH`, 4 — number of input bits (1..32).
- `DEBOUNCE_CYCLES`, 16'd50000 — consecutive stable cycles required to accept a new level; 0 bypasses debounce.
- `EDGE_TYPE`, 0 — 0 rising, 1 falling, 2 any edge.
- `RESET_LEVEL`, {WIDTH{1'b1}} — reset value of synchronizer and debounced state (KEYs idle high).
- `clk` in 1 — system clock.
- `reset_n` in 1 — reset, synchronous, active-low.
- `address` in 2 — register select.
- `chipselect` in 1 — slave select.
- `read_n` in 1 — read strobe, active-low.
- `write_n` in 1 — write strobe, active-low.
- `writedata` in 32 — write data.
- `in_port` in WIDTH — asynchronous external inputs.
- `readdata` out 32 — registered read data, zero-extended.
- `irq` out 1 — level interrupt, active-high.

## Operation
- Register map: 0 DATA (RO, debounced level); 1 reserved (reads 0, writes ignored); 2 IRQMASK (RW, WIDTH bits); 3 EDGECAP (read; write-1-to-clear).
- Write strobe: `chipselect && !write_n`. Read strobe: `chipselect && !read_n`.
- Synchronizer: two flops per bit, reset to RESET_LEVEL.
- Debounce per bit: counter clears whenever sync bit equals debounced bit; otherwise increments; when count reaches DEBOUNCE_CYCLES-1 the debounced bit takes the sync value and counter clears. A glitch shorter than DEBOUNCE_CYCLES changes nothing. Counter width = clog2(DEBOUNCE_CYCLES)+1.
- Edge detect: `prev` register follows debounced value; edge event per EDGE_TYPE on (debounced, prev).
- EDGECAP bit sets on event, holds until written 1. Simultaneous event and W1C on same bit: set wins.
- `irq = |(EDGECAP & IRQMASK)`, combinational from registers.
- Writes to DATA ignored. Upper writedata bits beyond WIDTH ignored.
- Reset: readdata 0, irq 0, IRQMASK 0, EDGECAP 0, debounced/prev/sync = RESET_LEVEL, counters 0. Reset mid-debounce discards pending change; no edge generated by reset itself.

## Timing
- Read latency 1: readdata updated on the edge after a read strobe, holds otherwise.
- in_port level change stable from cycle t: sync output at t+2; debounced at t+2+DEBOUNCE_CYCLES (bypass: t+2); EDGECAP and irq one cycle after debounced.
- IRQMASK/EDGECAP write effective on the next edge; irq follows in the same cycle as register change.
- Read of EDGECAP in same cycle as W1C returns pre-clear value.

## Structure
- Package `karaoke_pio_pkg`: address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3; EDGE_TYPE encodings.
- Sub-module `karaoke_pio_debounce` (one bit: sync in, counter, debounced out), generated WIDTH times; top holds registers, edge logic, bus decode.

## Test plan
- Reset with in_port=4'hF: readdata on DATA read = 32'h0000000F, irq=0, EDGECAP read = 0.
- DEBOUNCE_CYCLES=4, EDGE_TYPE=1: bit 0 low for 3 cycles then high -> DATA stays 4'hF, EDGECAP 0; low for 10 cycles -> DATA 4'hE, EDGECAP 4'h1 at t+7.
- IRQMASK=4'h1 then falling edge on bit 0 -> irq high; write EDGECAP 32'h1 -> irq low next cycle; IRQMASK=0 with edge on bit 1 -> EDGECAP 4'h2, irq stays 0.
- W1C of bit 2 same cycle as new bit-2 edge -> EDGECAP bit 2 remains 1.
- EDGE_TYPE=2, DEBOUNCE_CYCLES=0: bit 3 pulses low 5 cycles -> EDGECAP bit 3 set after fall, stays set after rise; reset_n low mid-pulse -> all state back to reset values, irq 0.

Source files
------------

// File: rtl/karaoke_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : karaoke_pio_pkg
//  Description : Shared register addresses and edge-type encodings for the
//                edge-capturing input PIO.
//  Revision    : 1.0 - initial release
// ============================================================================
package karaoke_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // One-bit edge qualifier: compares the current debounced level to the
    // level one cycle earlier.
    function automatic logic edge_event(input int etype, input logic cur, input logic prev);
        case (etype)
            EDGE_RISE: return cur & ~prev;
            EDGE_FALL: return ~cur & prev;
            default:   return cur ^ prev;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/karaoke_pio_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : karaoke_pio_debounce
//  Description : One input bit: two-flop synchronizer followed by a
//                stability counter. A new level is accepted only after it
//                has been seen for DEBOUNCE_CYCLES consecutive cycles;
//                DEBOUNCE_CYCLES = 0 passes the synchronized bit straight out.
//  Revision    : 1.0 - initial release
// ============================================================================
module karaoke_pio_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_async,
    output logic level
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Synchronizer next-state: plain shift of the asynchronous input.
    always_comb begin
        meta_d = in_async;
        sync_d = meta_q;
    end

    // Synchronizer flops, reset to the idle level of the line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= RESET_LEVEL;
            sync_q <= RESET_LEVEL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign level = sync_q;
        end else begin : g_filter
            localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
            localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          deb_q, deb_d;

            // Count cycles the synchronized bit disagrees with the accepted
            // level; any agreement restarts the count, so glitches vanish.
            always_comb begin
                cnt_d = cnt_q;
                deb_d = deb_q;
                if (sync_q == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    deb_d = sync_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Counter and accepted level registers.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                    deb_q <= RESET_LEVEL;
                end else begin
                    cnt_q <= cnt_d;
                    deb_q <= deb_d;
                end
            end

            assign level = deb_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/karaoke_pio_in_edge.sv
`default_nettype none
// ============================================================================
//  Module      : karaoke_pio_in_edge
//  Description : Avalon-MM input PIO with per-bit debounce, edge capture
//                (write-1-to-clear) and a maskable level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module karaoke_pio_in_edge
    import karaoke_pio_pkg::*;
#(
    parameter int              WIDTH           = 4,
    parameter int unsigned     DEBOUNCE_CYCLES = 16'd50000,
    parameter int              EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_LEVEL    = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] prev_q,    prev_d;
    logic [WIDTH-1:0] mask_q,    mask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] w1c;
    logic             wr_stb;
    logic             rd_stb;
    logic             unused_wdata;

    // Bits of writedata above WIDTH have no register behind them.
    assign unused_wdata = ^writedata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            karaoke_pio_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_LEVEL     (RESET_LEVEL[i])
            ) u_debounce (
                .clk      (clk),
                .reset_n  (reset_n),
                .in_async (in_port[i]),
                .level    (deb[i])
            );
        end
    endgenerate

    // Bus decode, edge qualification and register next-state.
    always_comb begin
        wr_stb = chipselect && !write_n;
        rd_stb = chipselect && !read_n;

        for (int i = 0; i < WIDTH; i++) begin
            evt[i] = edge_event(EDGE_TYPE, deb[i], prev_q[i]);
        end

        w1c = '0;
        if (wr_stb && (address == ADDR_EDGECAP)) begin
            w1c = writedata[WIDTH-1:0];
        end

        prev_d    = deb;
        // A fresh edge outranks a simultaneous clear of the same bit.
        edgecap_d = (edgecap_q & ~w1c) | evt;

        mask_d = mask_q;
        if (wr_stb && (address == ADDR_IRQMASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end

        readdata_d = readdata_q;
        if (rd_stb) begin
            readdata_d = '0;
            case (address)
                ADDR_DATA:    readdata_d[WIDTH-1:0] = deb;
                ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
                ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
                default:      readdata_d = '0;
            endcase
        end
    end

    // Register file and edge history.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q     <= RESET_LEVEL;
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= prev_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & mask_q);

endmodule
`default_nettype wire
